ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 229 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte using the inhibit/request-to-send
// handshake, shifts the bits out on device clock edges and checks the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int SETUP_CYCLES   = 250,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    inout  wire        ps2_clk,
    inout  wire        ps2_dat,
    output logic       busy,
    output logic       rx_inhibit,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] err_code
);

    localparam int T_A  = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int T_B  = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
    localparam int T_M  = (T_A > T_B) ? T_A : T_B;
    localparam int TW   = $clog2(T_M + 1) + 1;
    localparam int FW   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] SETUP_LAST = TW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0] XFER_LAST  = TW'(XFER_TIMEOUT - 1);
    localparam logic [FW-1:0] FILT_LAST  = FW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t            state;
    logic              clk_oe;
    logic              dat_oe;
    logic [7:0]        shreg;
    logic              parity;
    logic [3:0]        bit_cnt;
    logic [TW-1:0]     timer;

    // index 0 = ps2_clk, index 1 = ps2_dat
    logic [1:0]        sync1;
    logic [1:0]        sync2;
    logic [1:0]        filt;
    logic [1:0][FW-1:0] fcnt;
    logic              clk_prev;
    logic              fall;

    logic              abort;
    logic [1:0]        abort_code;

    assign ps2_clk    = clk_oe ? 1'b0 : 1'bz;
    assign ps2_dat    = dat_oe ? 1'b0 : 1'bz;
    assign rx_inhibit = busy;
    assign fall       = clk_prev & ~filt[0];

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            sync1    <= '1;
            sync2    <= '1;
            filt     <= '1;
            fcnt     <= '0;
            clk_prev <= 1'b1;
        end else begin
            sync1    <= {ps2_dat, ps2_clk};
            sync2    <= sync1;
            clk_prev <= filt[0];
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FILT_LAST) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    // The timer measures start timeout until the first edge, then transfer timeout up to idle.
    always_comb begin
        abort      = 1'b0;
        abort_code = 2'b00;
        case (state)
            SHIFT: begin
                if (!fall) begin
                    if (bit_cnt == 4'd0) begin
                        if (timer >= START_LAST) begin
                            abort      = 1'b1;
                            abort_code = 2'b01;
                        end
                    end else if (timer >= XFER_LAST) begin
                        abort      = 1'b1;
                        abort_code = 2'b10;
                    end
                end
            end
            ACK: begin
                if (fall) begin
                    if (filt[1]) begin
                        abort      = 1'b1;
                        abort_code = 2'b11;
                    end
                end else if (timer >= XFER_LAST) begin
                    abort      = 1'b1;
                    abort_code = 2'b10;
                end
            end
            WAIT_IDLE: begin
                if (filt != 2'b11 && timer >= XFER_LAST) begin
                    abort      = 1'b1;
                    abort_code = 2'b10;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            clk_oe   <= 1'b0;
            dat_oe   <= 1'b0;
            shreg    <= '0;
            parity   <= 1'b0;
            bit_cnt  <= '0;
            timer    <= '0;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            err_code <= 2'b00;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            if (timer != '1) begin
                timer <= timer + 1'b1;
            end
            if (abort) begin
                state    <= IDLE;
                clk_oe   <= 1'b0;
                dat_oe   <= 1'b0;
                bit_cnt  <= '0;
                tx_ready <= 1'b1;
                busy     <= 1'b0;
                tx_error <= 1'b1;
                err_code <= abort_code;
            end else begin
                case (state)
                    IDLE: begin
                        if (tx_valid && tx_ready) begin
                            shreg    <= tx_data;
                            parity   <= ~^tx_data;
                            err_code <= 2'b00;
                            tx_ready <= 1'b0;
                            busy     <= 1'b1;
                            clk_oe   <= 1'b1;
                            dat_oe   <= 1'b0;
                            timer    <= '0;
                            state    <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (timer >= INH_LAST) begin
                            dat_oe <= 1'b1;
                            timer  <= '0;
                            state  <= REQ;
                        end
                    end
                    REQ: begin
                        if (timer >= SETUP_LAST) begin
                            clk_oe  <= 1'b0;
                            bit_cnt <= '0;
                            timer   <= '0;
                            state   <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (fall) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 4'd0) begin
                                timer <= '0;
                            end
                            if (bit_cnt < 4'd8) begin
                                dat_oe <= ~shreg[bit_cnt[2:0]];
                            end else if (bit_cnt == 4'd8) begin
                                dat_oe <= ~parity;
                            end else begin
                                dat_oe <= 1'b0;
                                state  <= ACK;
                            end
                        end
                    end
                    ACK: begin
                        if (fall) begin
                            state <= WAIT_IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        if (filt == 2'b11) begin
                            state    <= IDLE;
                            bit_cnt  <= '0;
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                            tx_done  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model on pulled-up open-drain lines.
module tb_ps2_host_tx;

    localparam int INH   = 50;
    localparam int SETUP = 10;
    localparam int START = 2000;
    localparam int XFER  = 1500;
    localparam int FLEN  = 8;
    localparam int HALF  = 30;

    logic       sys_clk  = 1'b0;
    logic       reset    = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, rx_inhibit, tx_done, tx_error;
    logic [1:0] err_code;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    wire        ps2_clk;
    wire        ps2_dat;

    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_dat);

    always #5 sys_clk = ~sys_clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .SETUP_CYCLES  (SETUP),
        .START_TIMEOUT (START),
        .XFER_TIMEOUT  (XFER),
        .FILTER_LEN    (FLEN)
    ) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .busy      (busy),
        .rx_inhibit(rx_inhibit),
        .tx_done   (tx_done),
        .tx_error  (tx_error),
        .err_code  (err_code)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0, err_cnt = 0, overlap = 0, ready_miss = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_error) err_cnt <= err_cnt + 1;
        if (tx_done && tx_error) overlap <= overlap + 1;
        if ((tx_done || tx_error) && !tx_ready) ready_miss <= ready_miss + 1;
    end

    typedef struct {
        logic [7:0]  data;
        bit          ack_low;
        logic [10:0] frame;   // {stop, parity, d7..d0, start}
        logic [1:0]  err;
        int          n_done;
        int          n_err;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge sys_clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge sys_clk);
        tx_valid = 1'b0;
        tx_data  = ~d;
    endtask

    task automatic dev_run(input int n_edges, input bit ack_low,
                           output logic [10:0] bits, output bit ok, output int fall_cyc);
        int t;
        bits     = '1;
        ok       = 1'b0;
        fall_cyc = 0;
        t        = 0;
        while (!(busy && ps2_clk === 1'b1 && ps2_dat === 1'b0) && t < INH + SETUP + 100) begin
            @(negedge sys_clk);
            t++;
        end
        if (t >= INH + SETUP + 100) return;
        bits[0] = ps2_dat;
        repeat (HALF) @(negedge sys_clk);
        for (int k = 1; k <= n_edges; k++) begin
            if (k == 1) fall_cyc = cyc;
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge sys_clk);
            if (k <= 10) bits[k] = ps2_dat;
            dev_clk_low = 1'b0;
            if (k == 10 && ack_low) dev_dat_low = 1'b1;
            if (k == 11) dev_dat_low = 1'b0;
            repeat (HALF) @(negedge sys_clk);
        end
        ok = 1'b1;
    endtask

    task automatic wait_ready(input int limit);
        int t;
        t = 0;
        while (!tx_ready && t < limit) begin
            @(negedge sys_clk);
            t++;
        end
        check("return_to_idle", tx_ready, 1'b1);
    endtask

    task automatic run_vec(input vec_t v);
        int d0, e0, fc;
        logic [10:0] bits;
        bit ok;
        d0 = done_cnt;
        e0 = err_cnt;
        send(v.data);
        check("accept_ready_low", tx_ready, 1'b0);
        check("accept_busy", busy, 1'b1);
        check("accept_rx_inhibit", rx_inhibit, 1'b1);
        check("accept_err_clear", err_code, 2'b00);
        repeat (5) @(negedge sys_clk);
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        @(negedge sys_clk);
        tx_valid = 1'b0;
        dev_run(11, v.ack_low, bits, ok, fc);
        check("dev_request_seen", ok, 1'b1);
        check("frame_bits", bits, v.frame);
        wait_ready(200);
        repeat (2) @(negedge sys_clk);
        check("done_pulses", done_cnt - d0, v.n_done);
        check("error_pulses", err_cnt - e0, v.n_err);
        check("err_code", err_code, v.err);
        check("clk_released", ps2_clk, 1'b1);
        check("dat_released", ps2_dat, 1'b1);
    endtask

    initial begin
        int t, dat_low_at, rel_at, d0, e0, fc, start_c;
        logic [10:0] bits;
        bit ok;

        vecs[0] = '{8'hED, 1'b1, 11'b11_11101101_0, 2'b00, 1, 0};
        vecs[1] = '{8'h01, 1'b1, 11'b10_00000001_0, 2'b00, 1, 0};
        vecs[2] = '{8'h00, 1'b0, 11'b11_00000000_0, 2'b11, 0, 1};
        vecs[3] = '{8'hFF, 1'b1, 11'b11_11111111_0, 2'b00, 1, 0};
        vecs[4] = '{8'hF4, 1'b1, 11'b10_11110100_0, 2'b00, 1, 0};

        repeat (3) @(negedge sys_clk);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_rx_inhibit", rx_inhibit, 1'b0);
        check("rst_done_err", {tx_done, tx_error}, 2'b00);
        check("rst_err_code", err_code, 2'b00);
        check("rst_lines", {ps2_clk, ps2_dat}, 2'b11);
        reset = 1'b1;
        repeat (3) @(negedge sys_clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Device never clocks: check inhibit/setup timing and start timeout.
        e0 = err_cnt;
        send(8'h12);
        t = 0; dat_low_at = -1; rel_at = -1;
        while (t < INH + SETUP + START + 50) begin
            @(posedge sys_clk);
            #1;
            t++;
            if (dat_low_at < 0 && ps2_dat === 1'b0) dat_low_at = t;
            if (rel_at < 0 && dat_low_at >= 0 && ps2_clk === 1'b1) rel_at = t;
            if (tx_error) break;
        end
        check("inhibit_len", dat_low_at, INH);
        check("setup_len", rel_at, INH + SETUP);
        check("start_timeout_cycle", t, INH + SETUP + START);
        check("start_timeout_code", err_code, 2'b01);
        check("start_timeout_ready", tx_ready, 1'b1);
        @(posedge sys_clk);
        #1;
        check("start_timeout_lines", {ps2_clk, ps2_dat}, 2'b11);
        check("start_timeout_pulse_len", tx_error, 1'b0);
        check("start_timeout_err_pulses", err_cnt - e0, 1);

        // Device stops after edge 5, then a short clock glitch: no advance, transfer timeout.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h10);
        dev_run(5, 1'b0, bits, ok, fc);
        check("stall_request_seen", ok, 1'b1);
        check("stall_first_bits", bits[5:0], 6'b100000);
        dev_clk_low = 1'b1;
        repeat (3) @(negedge sys_clk);
        dev_clk_low = 1'b0;
        repeat (40) @(negedge sys_clk);
        check("glitch_no_advance", ps2_dat, 1'b1);
        t = 0;
        while (!tx_error && t < XFER + 200) begin
            @(posedge sys_clk);
            #1;
            t++;
        end
        start_c = cyc - fc;
        check("xfer_timeout_window", (start_c >= XFER + 5) && (start_c <= XFER + 20), 1'b1);
        check("xfer_timeout_code", err_code, 2'b10);
        repeat (2) @(negedge sys_clk);
        check("xfer_timeout_pulses", {done_cnt - d0, err_cnt - e0}, {32'd0, 32'd1});

        // Reset while bit 4 (a zero) is being driven.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h0F);
        dev_run(5, 1'b1, bits, ok, fc);
        check("rst_mid_request_seen", ok, 1'b1);
        check("rst_mid_bit4_driven", ps2_dat, 1'b0);
        @(negedge sys_clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_lines", {ps2_clk, ps2_dat}, 2'b11);
        check("rst_mid_ready", tx_ready, 1'b1);
        check("rst_mid_busy", {busy, rx_inhibit}, 2'b00);
        repeat (4) @(negedge sys_clk);
        reset = 1'b1;
        repeat (4) @(negedge sys_clk);
        check("rst_mid_no_pulses", {done_cnt - d0, err_cnt - e0}, {32'd0, 32'd0});
        run_vec(vecs[4]);

        check("done_error_overlap", overlap, 0);
        check("ready_with_pulse", ready_miss, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
